rgb_hue_sequencer: RTL
======================

# rgb_hue_sequencer

Three-channel PWM controller that sequences red, green and blue duty values around a six-phase colour wheel, producing a continuously cycling hue on one RGB LED (or one matrix colour group). It owns a shared PWM frame counter, per-channel duty registers and a phase state machine, and drives three PWM outputs directly. It sits between the top-level clock and the LED drive pins and replaces free-running single-channel PWM generators.

## Interface
- PERIOD, 5000: clocks per PWM frame (10 kHz at 50 MHz); legal range ≥ 2
- MAX_DUTY, 4000: peak duty in clocks; must satisfy 1 ≤ MAX_DUTY ≤ PERIOD
- STEP, 1: duty increment/decrement per update; legal range 1..MAX_DUTY
- FRAMES_PER_STEP, 1: frames between duty updates; legal range ≥ 1
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- enable  in  1  run when high; low forces IDLE
- hold  in  1  freeze duties and phase; PWM keeps running
- pwm_r / pwm_g / pwm_b  out  1 each  registered PWM outputs
- phase  out  3  current wheel phase, 0..5; 0 while idle
- frame_tick  out  1  one-cycle pulse on the last clock of each frame

## Operation
- Frame counter cnt runs 0..PERIOD-1, then wraps to 0. Width is $clog2(PERIOD).
- Duty registers are $clog2(PERIOD+1) bits wide.
- Channel output: pwm_x ← (cnt < duty_x).
  - duty 0: output constantly low.
  - duty = PERIOD: output constantly high.
- Step counter counts frame_tick events. Every FRAMES_PER_STEP-th tick it issues an update, provided hold is low.
- A tick with hold high neither counts nor updates.
- Phase state machine, as (constant channels; moving channel):
  - P0: R=MAX, B=0; G rises.
  - P1: G=MAX, B=0; R falls.
  - P2: G=MAX, R=0; B rises.
  - P3: B=MAX, R=0; G falls.
  - P4: B=MAX, G=0; R rises.
  - P5: R=MAX, G=0; B falls. P5 → P0.
- IDLE is entered while enable is low. In IDLE:
  - cnt = 0, step counter = 0
  - duties R=MAX_DUTY, G=0, B=0
  - phase = 0, all PWM outputs low, frame_tick low
- IDLE → P0 on the first clock with enable high.
- Rising channel on update: duty ← min(duty+STEP, MAX_DUTY).
- Falling channel on update: duty ← max(duty−STEP, 0).
- Arithmetic is computed one bit wider so it cannot overflow.
- Phase advances in the same update that makes the moving channel hit its limit (MAX_DUTY when rising, 0 when falling).
- The next phase's moving channel first changes on the following update.
- hold and enable interaction: enable low overrides hold. hold has no effect in IDLE.

## Timing
- Reset values: pwm_r/g/b = 0, frame_tick = 0, phase = 0; internal state as IDLE.
- frame_tick is combinational from cnt == PERIOD-1, gated by enable. It is high for exactly one clock per frame.
- Duty updates are applied at the clock edge ending the frame_tick cycle. The new duty therefore governs the whole next frame, starting at cnt = 0.
- Duty never changes mid-frame.
- PWM output latency: exactly 1 clock after cnt.
- In the first frame after enable rises, pwm_r goes high on the 2nd enabled clock and stays high for MAX_DUTY clocks.
- enable falling mid-frame: IDLE values are loaded on the next edge, and all outputs are low one clock later.
- rst asserted mid-operation: all outputs are cleared immediately and asynchronously. Operation resumes at P0 on the first clock edge after release if enable is high.

## Structure
- A shared package/header holds:
  - phase encodings PH_IDLE, PH_0..PH_5 (IDLE encoded distinctly internally; phase output 0)
  - width helpers CNT_W = $clog2(PERIOD) and DUTY_W = $clog2(PERIOD+1)
- Sub-module pwm_compare (parameter DUTY_W) is instantiated three times. Each instance takes cnt and duty and returns one registered output, cleared by rst and gated by enable.
- The frame counter, step counter and phase FSM live in the top module.

## Test plan
- Reset and idle: assert rst with enable=1 → all outputs 0 immediately. Hold enable=0 for 20 clocks → outputs stay 0 and phase=0.
- Sweep (PERIOD=10, MAX_DUTY=8, STEP=2, FRAMES_PER_STEP=1):
  - G duty per frame is 0,2,4,6,8; phase goes 0→1 on the update that sets 8.
  - R then falls 8,6,4,2,0.
  - Verify the pwm_g high count per frame equals its duty.
- Full wheel, same parameters: the phase sequence is 0,1,2,3,4,5, then back to 0 after 24 updates (240 clocks). Duties return to R=8, G=0, B=0.
- Clamping (MAX_DUTY=7, STEP=2): G duties are 0,2,4,6,7. The phase advances at 7, and R then falls 7,5,3,1,0.
- Hold and prescale (FRAMES_PER_STEP=3): with hold low, updates occur every 3rd frame_tick. Assert hold for 5 frames → duties and phase unchanged while frame_tick keeps pulsing. Release → counting resumes where it stopped.
- Disruption: drop enable mid-P3, mid-frame → outputs low one clock later. Re-enable → P0 with R=MAX. Repeat using rst in place of enable and check the same outcome.

Source files
------------

// File: rtl/rgb_hue_sequencer_pkg.sv
// Shared phase encodings and width helpers for the RGB hue sequencer.
package rgb_hue_sequencer_pkg;

    localparam logic [2:0] PH_0    = 3'd0;
    localparam logic [2:0] PH_1    = 3'd1;
    localparam logic [2:0] PH_2    = 3'd2;
    localparam logic [2:0] PH_3    = 3'd3;
    localparam logic [2:0] PH_4    = 3'd4;
    localparam logic [2:0] PH_5    = 3'd5;
    // Kept distinct from PH_0 internally; reported externally as phase 0.
    localparam logic [2:0] PH_IDLE = 3'd7;

    function automatic int unsigned cnt_width(input int unsigned period);
        return $clog2(period);
    endfunction

    function automatic int unsigned duty_width(input int unsigned period);
        return $clog2(period + 1);
    endfunction

    function automatic logic [2:0] next_phase(input logic [2:0] ph);
        return (ph == PH_5) ? PH_0 : ph + 3'd1;
    endfunction

    function automatic logic is_rising(input logic [2:0] ph);
        return (ph == PH_0) || (ph == PH_2) || (ph == PH_4);
    endfunction

endpackage

// File: rtl/rgb_hue_sequencer_if.sv
// Control and LED-drive signals of the RGB hue sequencer.
interface rgb_hue_sequencer_if;

    logic       enable;
    logic       hold;
    logic       pwm_r;
    logic       pwm_g;
    logic       pwm_b;
    logic [2:0] phase;
    logic       frame_tick;

    modport master (
        output enable, hold,
        input  pwm_r, pwm_g, pwm_b, phase, frame_tick
    );

    modport slave (
        input  enable, hold,
        output pwm_r, pwm_g, pwm_b, phase, frame_tick
    );

endinterface

// File: rtl/rgb_hue_sequencer_pwm_compare.sv
// One PWM channel: registered (cnt < duty), forced low while disabled.
module rgb_hue_sequencer_pwm_compare #(
    parameter int unsigned DUTY_W = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_i,
    input  logic [DUTY_W-1:0] cnt_i,
    input  logic [DUTY_W-1:0] duty_i,
    output logic              pwm_o
);

    logic pwm_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_q <= 1'b0;
        end else begin
            pwm_q <= enable_i & (cnt_i < duty_i);
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/rgb_hue_sequencer.sv
// Three-channel PWM hue sequencer: shared frame counter, step prescaler and
// six-phase colour-wheel FSM driving three duty registers.
module rgb_hue_sequencer
    import rgb_hue_sequencer_pkg::*;
#(
    parameter int unsigned PERIOD          = 5000,
    parameter int unsigned MAX_DUTY        = 4000,
    parameter int unsigned STEP            = 1,
    parameter int unsigned FRAMES_PER_STEP = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    rgb_hue_sequencer_if.slave   bus
);

    localparam int unsigned CNT_W  = cnt_width(PERIOD);
    localparam int unsigned DUTY_W = duty_width(PERIOD);
    localparam int unsigned STEP_W = $clog2(FRAMES_PER_STEP + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PERIOD - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FRAMES_PER_STEP - 1);
    localparam logic [DUTY_W-1:0] MAX_D     = DUTY_W'(MAX_DUTY);
    localparam logic [DUTY_W-1:0] STEP_D    = DUTY_W'(STEP);
    localparam logic [DUTY_W:0]   MAX_X     = (DUTY_W + 1)'(MAX_DUTY);
    localparam logic [DUTY_W:0]   STEP_X    = (DUTY_W + 1)'(STEP);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [2:0]        phase_q, phase_d;
    logic [DUTY_W-1:0] duty_r_q, duty_r_d;
    logic [DUTY_W-1:0] duty_g_q, duty_g_d;
    logic [DUTY_W-1:0] duty_b_q, duty_b_d;

    logic              frame_tick;
    logic [DUTY_W-1:0] mov_cur, mov_nxt, mov_dif;
    logic [DUTY_W:0]   mov_x, sum_x;
    logic              mov_hit;
    logic [DUTY_W-1:0] cnt_ext;

    assign frame_tick = bus.enable && (cnt_q == CNT_LAST);

    // Moving channel of the current phase and its clamped next value.
    always_comb begin
        case (phase_q)
            PH_1, PH_4: mov_cur = duty_r_q;
            PH_2, PH_5: mov_cur = duty_b_q;
            default:    mov_cur = duty_g_q;
        endcase
        mov_x   = {1'b0, mov_cur};
        sum_x   = mov_x + STEP_X;
        mov_dif = mov_cur - STEP_D;
        if (is_rising(phase_q)) begin
            mov_hit = (sum_x >= MAX_X);
            mov_nxt = mov_hit ? MAX_D : sum_x[DUTY_W-1:0];
        end else begin
            mov_hit = (mov_x <= STEP_X);
            mov_nxt = mov_hit ? '0 : mov_dif;
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        step_d   = step_q;
        phase_d  = phase_q;
        duty_r_d = duty_r_q;
        duty_g_d = duty_g_q;
        duty_b_d = duty_b_q;
        if (!bus.enable) begin
            cnt_d    = '0;
            step_d   = '0;
            phase_d  = PH_IDLE;
            duty_r_d = MAX_D;
            duty_g_d = '0;
            duty_b_d = '0;
        end else begin
            cnt_d = frame_tick ? '0 : cnt_q + CNT_W'(1);
            if (phase_q == PH_IDLE) begin
                phase_d = PH_0;
            end else if (frame_tick && !bus.hold) begin
                if (step_q != STEP_LAST) begin
                    step_d = step_q + STEP_W'(1);
                end else begin
                    step_d = '0;
                    case (phase_q)
                        PH_1, PH_4: duty_r_d = mov_nxt;
                        PH_2, PH_5: duty_b_d = mov_nxt;
                        default:    duty_g_d = mov_nxt;
                    endcase
                    if (mov_hit) begin
                        phase_d = next_phase(phase_q);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            step_q   <= '0;
            phase_q  <= PH_IDLE;
            duty_r_q <= MAX_D;
            duty_g_q <= '0;
            duty_b_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            step_q   <= step_d;
            phase_q  <= phase_d;
            duty_r_q <= duty_r_d;
            duty_g_q <= duty_g_d;
            duty_b_q <= duty_b_d;
        end
    end

    assign cnt_ext        = DUTY_W'(cnt_q);
    assign bus.phase      = (phase_q == PH_IDLE) ? 3'd0 : phase_q;
    assign bus.frame_tick = frame_tick;

    rgb_hue_sequencer_pwm_compare #(.DUTY_W(DUTY_W)) u_pwm_r (
        .clk      (clk),
        .rst      (rst),
        .enable_i (bus.enable),
        .cnt_i    (cnt_ext),
        .duty_i   (duty_r_q),
        .pwm_o    (bus.pwm_r)
    );

    rgb_hue_sequencer_pwm_compare #(.DUTY_W(DUTY_W)) u_pwm_g (
        .clk      (clk),
        .rst      (rst),
        .enable_i (bus.enable),
        .cnt_i    (cnt_ext),
        .duty_i   (duty_g_q),
        .pwm_o    (bus.pwm_g)
    );

    rgb_hue_sequencer_pwm_compare #(.DUTY_W(DUTY_W)) u_pwm_b (
        .clk      (clk),
        .rst      (rst),
        .enable_i (bus.enable),
        .cnt_i    (cnt_ext),
        .duty_i   (duty_b_q),
        .pwm_o    (bus.pwm_b)
    );

endmodule
